// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Owns the program counter and the instruction register. On a fetch request
// it reads one 32-bit word from instruction memory over a req/ack handshake,
// latches it into the IR, then advances the PC by 4. The IR is split into
// RISC-V style fields for the downstream control unit's decode step.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-low reset
//   fetch_start  request to fetch at the current PC (accepted in IDLE only)
//   pc_load      load pc_next into PC (IDLE only, wins over fetch_start)
//   pc_next      redirect target
//   mem_req      instruction memory read request (high throughout WAIT)
//   mem_addr     read address, always equal to PC
//   mem_ack      memory returns data this cycle (only honoured in WAIT)
//   mem_rdata    instruction word, valid with mem_ack
//   instr_valid  one-cycle pulse: new instruction in IR
//   fetch_busy   high in WAIT and DONE
//   fetch_err    one-cycle pulse: misaligned PC or memory timeout
//   pc           current PC
//   instr_pc     address of the instruction held in IR
//   ir           instruction register
//   opcode/rd/funct3/rs1/rs2/funct7  combinational slices of ir
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_start,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  instr_valid,
  output logic                  fetch_busy,
  output logic                  fetch_err,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [31:0]           ir,
  output logic [6:0]            opcode,
  output logic [4:0]            rd,
  output logic [2:0]            funct3,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [6:0]            funct7
);

  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
  localparam int unsigned     CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic [31:0]           r_ir;
  logic [CW-1:0]         r_cnt;
  logic                  r_fetch_err;
  logic                  w_start;
  logic                  w_misalign;
  logic                  w_timeout;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and event decode
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_misalign   = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // pc_load takes priority; a fetch request in the same cycle is dropped
        if (!pc_load && fetch_start) begin
          if (r_pc[1:0] != 2'b00) begin
            w_misalign = 1'b1;
          end else begin
            w_start      = 1'b1;
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // an ack on the final allowed cycle still completes the fetch
        if (mem_ack) begin
          w_state_next = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // PC, IR, timeout counter and error pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_instr_pc  <= RESET_PC;
      r_ir        <= NOP_INSTR;
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_fetch_err <= w_misalign | w_timeout;
      unique case (r_state)
        S_IDLE: begin
          if (pc_load) begin
            r_pc <= pc_next;
          end else if (w_start) begin
            r_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_ir       <= mem_rdata;
            r_instr_pc <= r_pc;
          end else if (!w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_pc <= r_pc + ADDR_WIDTH'(4);
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign mem_req     = (r_state == S_WAIT);
  assign mem_addr    = r_pc;
  assign instr_valid = (r_state == S_DONE);
  assign fetch_busy  = (r_state == S_WAIT) || (r_state == S_DONE);
  assign fetch_err   = r_fetch_err;
  assign pc          = r_pc;
  assign instr_pc    = r_instr_pc;
  assign ir          = r_ir;

  assign opcode = r_ir[6:0];
  assign rd     = r_ir[11:7];
  assign funct3 = r_ir[14:12];
  assign rs1    = r_ir[19:15];
  assign rs2    = r_ir[24:20];
  assign funct7 = r_ir[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for instr_fetch_unit: randomized fetches, redirects, timeouts and
// resets against an architectural model of PC/IR/instr_pc. Completion events
// (instr_valid / fetch_err) are checked by an independent monitor popping a
// scoreboard queue filled by the stimulus side.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int unsigned    AW  = 32;
  localparam logic [AW-1:0]  RPC = '0;
  localparam int unsigned    TO  = 15;
  localparam logic [31:0]    NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_start = 1'b0;
  logic          pc_load = 1'b0;
  logic [AW-1:0] pc_next = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          instr_valid;
  logic          fetch_busy;
  logic          fetch_err;
  logic [AW-1:0] pc;
  logic [AW-1:0] instr_pc;
  logic [31:0]   ir;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [2:0]    funct3;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [6:0]    funct7;

  instr_fetch_unit #(
    .ADDR_WIDTH(AW),
    .RESET_PC  (RPC),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_start(fetch_start),
    .pc_load    (pc_load),
    .pc_next    (pc_next),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr_valid(instr_valid),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err),
    .pc         (pc),
    .instr_pc   (instr_pc),
    .ir         (ir),
    .opcode     (opcode),
    .rd         (rd),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct7     (funct7)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit            is_err;
    logic [31:0]   ir;
    logic [AW-1:0] ipc;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t sb[$];

  // architectural model
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_ipc;
  logic [31:0]   m_ir;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit is_err, input logic [31:0] e_ir,
                          input logic [AW-1:0] e_ipc, input logic [AW-1:0] e_pc);
    exp_t e;
    e.is_err = is_err;
    e.ir     = e_ir;
    e.ipc    = e_ipc;
    e.pc     = e_pc;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every instr_valid / fetch_err pulse must match the next expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (instr_valid && fetch_err) chk("valid_err_exclusive", 1, 0);
        if (instr_valid || fetch_err) begin
          if (sb.size() == 0) begin
            chk("unexpected_event", {62'd0, instr_valid, fetch_err}, 0);
          end else begin
            e = sb.pop_front();
            chk("event_kind", {62'd0, instr_valid, fetch_err}, e.is_err ? 64'd1 : 64'd2);
            chk("ev_ir", ir, e.ir);
            chk("ev_instr_pc", instr_pc, e.ipc);
            chk("ev_pc", pc, e.pc);
            chk("ev_busy", fetch_busy, !e.is_err);
            chk("ev_mem_req", mem_req, 0);
            chk("ev_opcode", opcode, e.ir[6:0]);
            chk("ev_rd", rd, e.ir[11:7]);
            chk("ev_funct3", funct3, e.ir[14:12]);
            chk("ev_rs1", rs1, e.ir[19:15]);
            chk("ev_rs2", rs2, e.ir[24:20]);
            chk("ev_funct7", funct7, e.ir[31:25]);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_pc  = RPC;
    m_ipc = RPC;
    m_ir  = NOP;
    @(negedge clk);
    chk("rst_pc", pc, RPC);
    chk("rst_instr_pc", instr_pc, RPC);
    chk("rst_ir", ir, NOP);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_err", fetch_err, 0);
    tick();
  endtask

  task automatic redirect(input logic [AW-1:0] target, input bit with_fetch);
    pc_load     = 1'b1;
    pc_next     = target;
    fetch_start = with_fetch;
    tick();
    pc_load     = 1'b0;
    fetch_start = 1'b0;
    pc_next     = $urandom;
    m_pc        = target;
    @(negedge clk);
    chk("redirect_pc", pc, target);
    chk("redirect_no_req", mem_req, 0);
    tick();
  endtask

  // lat = index of the WAIT cycle carrying mem_ack; lat >= TO means no ack
  task automatic fetch(input int unsigned lat, input logic [31:0] data, input bit noise);
    bit acked;
    acked       = 1'b0;
    fetch_start = 1'b1;
    mem_ack     = noise ? 1'($urandom % 2) : 1'b0;
    mem_rdata   = $urandom;
    if (m_pc[1:0] != 2'b00) push_exp(1'b1, m_ir, m_ipc, m_pc);
    tick();
    fetch_start = 1'b0;
    mem_ack     = 1'b0;
    if (m_pc[1:0] != 2'b00) begin
      @(negedge clk);
      chk("misalign_no_req", mem_req, 0);
      chk("misalign_pc", pc, m_pc);
      tick();
      return;
    end
    for (int unsigned i = 0; i < TO; i++) begin
      if (noise) begin
        fetch_start = 1'($urandom % 2);
        pc_load     = 1'($urandom % 2);
        pc_next     = $urandom;
      end
      if (i == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = data;
        push_exp(1'b0, data, m_pc, m_pc);
        acked = 1'b1;
      end else if (i == TO - 1) begin
        push_exp(1'b1, m_ir, m_ipc, m_pc);
      end
      @(negedge clk);
      chk("wait_req", mem_req, 1);
      chk("wait_addr", mem_addr, m_pc);
      chk("wait_busy", fetch_busy, 1);
      tick();
      mem_ack     = 1'b0;
      mem_rdata   = $urandom;
      fetch_start = 1'b0;
      pc_load     = 1'b0;
      if (acked) break;
    end
    if (acked) begin
      // DONE cycle: redirects and requests here must be ignored
      if (noise) begin
        fetch_start = 1'($urandom % 2);
        pc_load     = 1'($urandom % 2);
        pc_next     = $urandom;
      end
      m_ir  = data;
      m_ipc = m_pc;
      tick();
      fetch_start = 1'b0;
      pc_load     = 1'b0;
      m_pc        = m_pc + AW'(4);
      @(negedge clk);
      chk("done_pc_inc", pc, m_pc);
      chk("done_instr_pc", instr_pc, m_ipc);
      chk("done_idle_busy", fetch_busy, 0);
      chk("done_idle_req", mem_req, 0);
    end else begin
      @(negedge clk);
      chk("timeout_req_low", mem_req, 0);
      chk("timeout_pc", pc, m_pc);
      chk("timeout_ir", ir, m_ir);
      chk("timeout_busy", fetch_busy, 0);
    end
    tick();
  endtask

  // Reset asserted in a WAIT cycle that also carries mem_ack
  task automatic mid_wait_reset(input int unsigned k);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int unsigned i = 0; i < k; i++) begin
      @(negedge clk);
      chk("mid_wait_req", mem_req, 1);
      tick();
    end
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = $urandom;
    @(negedge clk);
    chk("mid_wait_req_before_rst", mem_req, 1);
    tick();
    reset   = 1'b1;
    mem_ack = 1'b0;
    m_pc    = RPC;
    m_ipc   = RPC;
    m_ir    = NOP;
    @(negedge clk);
    chk("midrst_ir", ir, NOP);
    chk("midrst_pc", pc, RPC);
    chk("midrst_instr_pc", instr_pc, RPC);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_req", mem_req, 0);
    tick();
  endtask

  initial begin
    logic [AW-1:0] addr;
    int unsigned   sel;

    do_reset();
    fetch(0, 32'h0050_0093, 1'b0);
    fetch(5, 32'h0020_81B3, 1'b0);
    fetch(TO, $urandom, 1'b0);
    redirect(32'h100, 1'b1);
    fetch($urandom_range(0, 4), $urandom, 1'b1);
    redirect(32'h102, 1'b0);
    fetch(0, $urandom, 1'b0);
    redirect(32'h200, 1'b0);
    mid_wait_reset(2);
    redirect(32'hFFFF_FFFC, 1'b0);
    fetch(1, $urandom, 1'b0);
    chk("wrap_pc_zero", pc, 0);
    fetch(TO - 1, $urandom, 1'b1);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        addr = $urandom;
        if ($urandom % 4 != 0) addr[1:0] = 2'b00;
        redirect(addr, 1'($urandom % 2));
      end else if (sel == 1) begin
        redirect(32'hFFFF_FFF8, 1'b0);
      end else if (sel == 2 && m_pc[1:0] == 2'b00) begin
        mid_wait_reset($urandom_range(0, 5));
      end else begin
        fetch($urandom_range(0, TO), $urandom, 1'($urandom % 2));
      end
    end

    tick();
    tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
